axi_lite_spi_bridge: RTL and testbench

AXI4-Lite slave exposing an SPI master with three 32-bit registers (control, status, data). It sits between the PS AXI general-purpose port and an external SPI device such as an M95xxx EEPROM. Chip select is driven outside this block. Writing the data register launches one 8-bit full-duplex transfer, and completion raises a status flag and an optional interrupt.

---
 rtl/axi_spi_pkg.sv | 55 +++++
 rtl/spi_master_shifter.sv | 113 +++++++++++
 rtl/axi_lite_spi_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_axi_lite_spi_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_spi_pkg.sv
// Shared definitions for the AXI4-Lite to SPI master bridge:
// register offsets, CTRL/STATUS bit positions, AXI response codes,
// the SCLK divider table and a bit-reverse helper.
package axi_spi_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_DATA   = 4'h8;

  localparam int CTRL_SPIE = 7;
  localparam int CTRL_SPE  = 6;
  localparam int CTRL_DORD = 5;
  localparam int CTRL_MSTR = 4;
  localparam int CTRL_CPOL = 3;
  localparam int CTRL_CPHA = 2;
  localparam int CTRL_SPR  = 0;

  localparam int STAT_SPIF = 7;
  localparam int STAT_WCOL = 6;
  localparam int STAT_BUSY = 0;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  localparam int HALF_W = 4;

  // Half-period reload value (half period minus one) for each SPR setting:
  // half periods of 2/4/8/16 clocks give SCLK periods of 4/8/16/32 clocks.
  function automatic logic [HALF_W-1:0] spr_half_m1(input logic [1:0] spr);
    logic [HALF_W-1:0] val;
    case (spr)
      2'd0:    val = 4'd1;
      2'd1:    val = 4'd3;
      2'd2:    val = 4'd7;
      default: val = 4'd15;
    endcase
    return val;
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// SPI master shift engine: half-period down-counter, SCLK generation,
// 8-bit TX/RX shift registers and a single-cycle done pulse.
// Settings are latched on start and frozen for the whole byte.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no transfer; sclk follows CPOL, mosi held at 0
// S_SHIFT | byte in flight; each terminal count emits one SCLK edge,
//         | with one extra half period at the end when CPHA=1
module spi_master_shifter
  import axi_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       dord,
  input  logic [1:0] spr,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e            state, state_nxt;
  logic [HALF_W-1:0] div_cnt, half_m1;
  logic [4:0]        tick_cnt;
  logic              cpha_q, dord_q;
  logic [7:0]        tx_sr, rx_sr;
  logic [7:0]        tx_load;
  logic              tick, last_tick, sample_edge, shift_edge;

  // Shifting always runs MSB first; LSB-first is handled by reversing in and out.
  assign tx_load     = dord ? bit_rev8(tx_byte) : tx_byte;
  assign tick        = (div_cnt == '0);
  assign last_tick   = cpha_q ? (tick_cnt == 5'd16) : (tick_cnt == 5'd15);
  assign sample_edge = !tick_cnt[4] && (tick_cnt[0] == cpha_q);
  assign shift_edge  = !tick_cnt[4] && (tick_cnt[0] != cpha_q) && !last_tick;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (tick && last_tick) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy    = (state == S_SHIFT);
    done    = (state == S_SHIFT) && tick && last_tick;
    rx_byte = dord_q ? bit_rev8(rx_sr) : rx_sr;
  end

  // Divider, SCLK toggling and shift datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      half_m1  <= '0;
      tick_cnt <= '0;
      cpha_q   <= 1'b0;
      dord_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else if (state == S_IDLE) begin
      sclk <= cpol;
      mosi <= 1'b0;
      if (start) begin
        half_m1  <= spr_half_m1(spr);
        div_cnt  <= spr_half_m1(spr);
        tick_cnt <= '0;
        cpha_q   <= cpha;
        dord_q   <= dord;
        rx_sr    <= '0;
        if (cpha) begin
          tx_sr <= tx_load;
        end else begin
          mosi  <= tx_load[7];
          tx_sr <= {tx_load[6:0], 1'b0};
        end
      end
    end else if (tick) begin
      div_cnt  <= half_m1;
      tick_cnt <= tick_cnt + 5'd1;
      if (!tick_cnt[4]) sclk <= ~sclk;
      if (sample_edge) rx_sr <= {rx_sr[6:0], miso};
      if (shift_edge) begin
        mosi  <= tx_sr[7];
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
      if (last_tick) mosi <= 1'b0;
    end else begin
      div_cnt <= div_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/axi_lite_spi_bridge.sv
// AXI4-Lite slave with CTRL/STATUS/DATA registers driving an 8-bit SPI master.
// Optional feature macro: AXI2SPI_IRQ_EN (stores SPIE and drives IRQ = SPIE & SPIF;
// when undefined IRQ is 0 and CTRL[7] reads 0).
module axi_lite_spi_bridge
  import axi_spi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic                FCLK_CLK0,
  input  logic                RST_N,
  input  logic [ADDR_W-1:0]   AXI_awaddr,
  input  logic [2:0]          AXI_awprot,
  input  logic                AXI_awvalid,
  output logic                AXI_awready,
  input  logic [DATA_W-1:0]   AXI_wdata,
  input  logic [DATA_W/8-1:0] AXI_wstrb,
  input  logic                AXI_wvalid,
  output logic                AXI_wready,
  output logic [1:0]          AXI_bresp,
  output logic                AXI_bvalid,
  input  logic                AXI_bready,
  input  logic [ADDR_W-1:0]   AXI_araddr,
  input  logic [2:0]          AXI_arprot,
  input  logic                AXI_arvalid,
  output logic                AXI_arready,
  output logic [DATA_W-1:0]   AXI_rdata,
  output logic [1:0]          AXI_rresp,
  output logic                AXI_rvalid,
  input  logic                AXI_rready,
  output logic                IRQ,
  input  logic                i_miso,
  output logic                o_mosi,
  output logic                o_sclk
);

`ifdef AXI2SPI_IRQ_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_MASK = 8'hFF ^ (8'h01 << CTRL_SPIE);
`endif

  // Only addr[3:2] selects a register; any set bit above that is unmapped.
  function automatic reg_sel_e decode_addr(input logic [ADDR_W-3:0] a);
    logic [3:0] ofs;
    reg_sel_e   sel;
    ofs = {a[1:0], 2'b00};
    if (a[ADDR_W-3:2] != '0)   sel = REG_NONE;
    else if (ofs == OFS_CTRL)   sel = REG_CTRL;
    else if (ofs == OFS_STATUS) sel = REG_STATUS;
    else if (ofs == OFS_DATA)   sel = REG_DATA;
    else                        sel = REG_NONE;
    return sel;
  endfunction

  logic       aw_got, w_got, aw_got_d, w_got_d, bvalid_d, rvalid_d;
  reg_sel_e   aw_sel_q, ar_sel;
  logic [7:0] w_byte_q;
  logic       aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_fire;
  logic       data_wr, data_rd, launch, collide;
  logic [7:0] ctrl_q, rx_data_q, status_byte, rd_byte;
  logic       spif, wcol;
  logic       xfer_busy, xfer_done;
  logic [7:0] xfer_rx;
  logic       unused_ok;

  assign unused_ok = ^{AXI_awprot, AXI_arprot, AXI_wstrb, AXI_wdata[DATA_W-1:8],
                       AXI_awaddr[1:0], AXI_araddr[1:0]};

  assign aw_hs   = AXI_awvalid & AXI_awready;
  assign w_hs    = AXI_wvalid & AXI_wready;
  assign ar_hs   = AXI_arvalid & AXI_arready;
  assign b_hs    = AXI_bvalid & AXI_bready;
  assign r_hs    = AXI_rvalid & AXI_rready;
  assign wr_fire = aw_got & w_got;
  assign ar_sel  = decode_addr(AXI_araddr[ADDR_W-1:2]);

  assign data_wr = wr_fire && (aw_sel_q == REG_DATA);
  assign data_rd = ar_hs && (ar_sel == REG_DATA);
  assign launch  = data_wr && ctrl_q[CTRL_SPE] && ctrl_q[CTRL_MSTR] && !xfer_busy;
  assign collide = data_wr && xfer_busy;

`ifdef AXI2SPI_IRQ_EN
  assign IRQ = ctrl_q[CTRL_SPIE] & spif;
`else
  assign IRQ = 1'b0;
`endif

  // Next-state of the write-channel bookkeeping
  always_comb begin
    aw_got_d = aw_got;
    w_got_d  = w_got;
    bvalid_d = AXI_bvalid;
    if (aw_hs) aw_got_d = 1'b1;
    if (w_hs)  w_got_d  = 1'b1;
    if (wr_fire) begin
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
      bvalid_d = 1'b1;
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end
  end

  // Write channel: capture AW/W independently, respond once both are in
  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      AXI_awready <= 1'b0;
      AXI_wready  <= 1'b0;
      AXI_bvalid  <= 1'b0;
      AXI_bresp   <= RESP_OKAY;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      aw_sel_q    <= REG_NONE;
      w_byte_q    <= '0;
    end else begin
      AXI_awready <= !aw_got_d && !bvalid_d;
      AXI_wready  <= !w_got_d && !bvalid_d;
      AXI_bvalid  <= bvalid_d;
      aw_got      <= aw_got_d;
      w_got       <= w_got_d;
      if (aw_hs) aw_sel_q <= decode_addr(AXI_awaddr[ADDR_W-1:2]);
      if (w_hs)  w_byte_q <= AXI_wdata[7:0];
      if (wr_fire) AXI_bresp <= (aw_sel_q == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read data mux
  always_comb begin
    status_byte            = '0;
    status_byte[STAT_SPIF] = spif;
    status_byte[STAT_WCOL] = wcol;
    status_byte[STAT_BUSY] = xfer_busy;
    case (ar_sel)
      REG_CTRL:   rd_byte = ctrl_q;
      REG_STATUS: rd_byte = status_byte;
      REG_DATA:   rd_byte = rx_data_q;
      default:    rd_byte = '0;
    endcase
  end

  assign rvalid_d = ar_hs ? 1'b1 : (r_hs ? 1'b0 : AXI_rvalid);

  // Read channel: one outstanding read, data registered at the AR handshake
  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      AXI_arready <= 1'b0;
      AXI_rvalid  <= 1'b0;
      AXI_rdata   <= '0;
      AXI_rresp   <= RESP_OKAY;
    end else begin
      AXI_arready <= !rvalid_d;
      AXI_rvalid  <= rvalid_d;
      if (ar_hs) begin
        AXI_rdata <= {{(DATA_W-8){1'b0}}, rd_byte};
        AXI_rresp <= (ar_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Register file; a completing transfer wins over a same-cycle flag clear
  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      ctrl_q    <= '0;
      rx_data_q <= '0;
      spif      <= 1'b0;
      wcol      <= 1'b0;
    end else begin
      if (wr_fire && (aw_sel_q == REG_CTRL)) ctrl_q <= w_byte_q & CTRL_MASK;
      if (data_wr || data_rd) begin
        spif <= 1'b0;
        wcol <= 1'b0;
      end
      if (collide) wcol <= 1'b1;
      if (xfer_done) begin
        spif      <= 1'b1;
        rx_data_q <= xfer_rx;
      end
    end
  end

  spi_master_shifter u_shifter (
    .clk     (FCLK_CLK0),
    .rst_n   (RST_N),
    .start   (launch),
    .tx_byte (w_byte_q),
    .cpol    (ctrl_q[CTRL_CPOL]),
    .cpha    (ctrl_q[CTRL_CPHA]),
    .dord    (ctrl_q[CTRL_DORD]),
    .spr     (ctrl_q[CTRL_SPR +: 2]),
    .miso    (i_miso),
    .sclk    (o_sclk),
    .mosi    (o_mosi),
    .busy    (xfer_busy),
    .done    (xfer_done),
    .rx_byte (xfer_rx)
  );

endmodule

// File: tb/tb_axi_lite_spi_bridge.sv
// Directed bench for axi_lite_spi_bridge with a small M95xxx-style EEPROM model
// (8-bit address, WREN/WRITE/READ, SPI mode 0).
`timescale 1ns/1ps
module tb_axi_lite_spi_bridge;

`ifdef AXI2SPI_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [7:0] PAT [6] = '{8'hAA, 8'hFF, 8'h00, 8'h55, 8'hC3, 8'h3C};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        irq, i_miso, o_mosi, o_sclk;
  logic        use_eeprom, miso_const, cs_n, miso_m;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0] pos_cap = '0, neg_cap = '0;

  always #5 clk = ~clk;

  assign i_miso = use_eeprom ? miso_m : miso_const;

  axi_lite_spi_bridge dut (
    .FCLK_CLK0(clk), .RST_N(rst_n),
    .AXI_awaddr(awaddr), .AXI_awprot(awprot), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
    .AXI_araddr(araddr), .AXI_arprot(arprot), .AXI_arvalid(arvalid), .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid), .AXI_rready(rready),
    .IRQ(irq), .i_miso(i_miso), .o_mosi(o_mosi), .o_sclk(o_sclk)
  );

  always @(posedge o_sclk) begin
    pos_cap = {pos_cap[6:0], o_mosi};
    pulses++;
  end
  always @(negedge o_sclk) neg_cap = {neg_cap[6:0], o_mosi};

  // EEPROM model
  logic [7:0] mem [256];
  logic [7:0] m_sr, m_out, m_cmd, m_addr;
  int         m_bits, m_bytes;
  bit         m_wel;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    m_sr = '0; m_out = '0; m_cmd = '0; m_addr = '0;
    m_bits = 0; m_bytes = 0; m_wel = 0; miso_m = 1'b0;
  end

  always @(negedge cs_n) begin
    m_bits = 0; m_bytes = 0; m_out = '0;
  end
  always @(posedge cs_n) if (m_cmd == 8'h02) m_wel = 0;

  always @(posedge o_sclk) if (use_eeprom && !cs_n) begin
    m_sr = {m_sr[6:0], o_mosi};
    m_bits++;
    if (m_bits == 8) begin
      m_bits = 0;
      m_bytes++;
      if (m_bytes == 1) begin
        m_cmd = m_sr;
        if (m_sr == 8'h06) m_wel = 1;
      end else begin
        if (m_bytes == 2) m_addr = m_sr;
        else if (m_cmd == 8'h02 && m_wel) begin
          mem[m_addr] = m_sr;
          m_addr++;
        end
        if (m_cmd == 8'h03) begin
          m_out = mem[m_addr];
          m_addr++;
        end
      end
    end
  end

  always @(negedge o_sclk) if (use_eeprom && !cs_n) begin
    miso_m = m_out[7];
    m_out  = {m_out[6:0], 1'b0};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    bit aw_ok, w_ok, hs_aw, hs_w;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    aw_ok = 0; w_ok = 0; n = 0;
    while (!(aw_ok && w_ok) && n < 100) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      n++;
      if (hs_aw) begin awvalid = 1'b0; aw_ok = 1; end
      if (hs_w)  begin wvalid  = 1'b0; w_ok  = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_ok && w_ok)) chk("aw_w_handshake", {30'd0, aw_ok, w_ok}, 32'd3);
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (!bvalid) begin
      chk("bvalid_timeout", {31'd0, bvalid}, 32'd1);
      resp = 2'b11;
    end else begin
      resp = bresp;
      @(negedge clk);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bit hs;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; n = 0; hs = 0;
    while (!hs && n < 100) begin
      hs = arready;
      @(negedge clk);
      n++;
    end
    arvalid = 1'b0;
    if (!hs) chk("ar_handshake", {31'd0, arready}, 32'd1);
    n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (!rvalid) begin
      chk("rvalid_timeout", {31'd0, rvalid}, 32'd1);
      d = '1; resp = 2'b11;
    end else begin
      d = rdata; resp = rresp;
      @(negedge clk);
    end
  endtask

  task automatic wait_spif(output logic [31:0] st);
    logic [1:0] r;
    int n;
    n = 0;
    st = '0;
    while (!st[7] && n < 200) begin axi_read(32'h4, st, r); n++; end
    if (!st[7]) chk("spif_timeout", st, 32'h80);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic [1:0]  r;
    logic [31:0] st, d;
    axi_write(32'h8, {24'd0, tx}, r);
    wait_spif(st);
    axi_read(32'h8, d, r);
    rx = d[7:0];
  endtask

  logic [31:0] d, st;
  logic [1:0]  r;
  logic [7:0]  rx;

  initial begin
    rst_n = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    use_eeprom = 0; miso_const = 1; cs_n = 1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 0);
    chk("rst_arready", {31'd0, arready}, 0);
    chk("rst_bvalid",  {31'd0, bvalid}, 0);
    chk("rst_rvalid",  {31'd0, rvalid}, 0);
    chk("rst_irq",     {31'd0, irq}, 0);
    chk("rst_sclk",    {31'd0, o_sclk}, 0);
    chk("rst_rdata",   rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", {31'd0, awready}, 1);
    chk("idle_wready",  {31'd0, wready}, 1);
    chk("idle_arready", {31'd0, arready}, 1);

    axi_read(32'h0, d, r); chk("ctrl_rst", d, 0); chk("ctrl_rst_resp", {30'd0, r}, 0);
    axi_read(32'h4, d, r); chk("stat_rst", d, 0); chk("stat_rst_resp", {30'd0, r}, 0);

    axi_write(32'h0, 32'hD2, r); chk("ctrl_wr_resp", {30'd0, r}, 0);
    axi_read(32'h0, d, r); chk("ctrl_readback", d, IRQ_EN ? 32'hD2 : 32'h52);

    // Mode 0, SPR=2, MISO held high
    pulses = 0; pos_cap = '0;
    axi_write(32'h8, 32'h06, r); chk("data_wr_resp", {30'd0, r}, 0);
    axi_read(32'h4, d, r); chk("stat_busy", d, 32'h01);
    wait_spif(st);
    chk("stat_done", st, 32'h80);
    chk("mosi_bits", {24'd0, pos_cap}, 32'h06);
    chk("pulse_count", pulses, 8);
    chk("irq_set", {31'd0, irq}, {31'd0, IRQ_EN});
    chk("sclk_idle", {31'd0, o_sclk}, 0);
    chk("mosi_idle", {31'd0, o_mosi}, 0);
    axi_read(32'h8, d, r); chk("rx_ff", d, 32'hFF);
    chk("irq_clr", {31'd0, irq}, 0);

    // Write collision
    pulses = 0; pos_cap = '0;
    axi_write(32'h8, 32'h02, r);
    repeat (40) @(negedge clk);
    axi_write(32'h8, 32'h03, r); chk("coll_resp", {30'd0, r}, 0);
    axi_read(32'h4, d, r); chk("coll_stat_busy", d, 32'h41);
    wait_spif(st);
    chk("coll_stat_done", st, 32'hC0);
    chk("coll_mosi", {24'd0, pos_cap}, 32'h02);
    chk("coll_pulses", pulses, 8);
    axi_read(32'h8, d, r);
    axi_read(32'h4, d, r); chk("stat_cleared", d, 0);

    // CPHA=1, LSB first, SPR=0
    axi_write(32'h0, 32'h74, r);
    pulses = 0; neg_cap = '0;
    axi_write(32'h8, 32'h06, r);
    wait_spif(st);
    chk("cpha1_stat", st, 32'h80);
    chk("cpha1_lsb_bits", {24'd0, neg_cap}, 32'h60);
    chk("cpha1_pulses", pulses, 8);
    chk("cpha1_irq", {31'd0, irq}, 0);
    axi_read(32'h8, d, r); chk("cpha1_rx", d, 32'hFF);

    // EEPROM write then read back
    axi_write(32'h0, 32'h52, r);
    use_eeprom = 1;
    cs_n = 0; spi_byte(8'h06, rx); cs_n = 1;
    repeat (5) @(negedge clk);
    cs_n = 0;
    spi_byte(8'h02, rx);
    spi_byte(8'h04, rx);
    for (int i = 0; i < 6; i++) spi_byte(PAT[i], rx);
    cs_n = 1;
    #10000;
    cs_n = 0;
    spi_byte(8'h03, rx);
    spi_byte(8'h04, rx);
    for (int i = 0; i < 6; i++) begin
      spi_byte(8'h00, rx);
      chk($sformatf("eeprom_rd%0d", i), {24'd0, rx}, {24'd0, PAT[i]});
    end
    cs_n = 1;
    use_eeprom = 0;

    // Unmapped and read-only addresses
    axi_write(32'h10, 32'hFF, r); chk("bad_wr_resp", {30'd0, r}, 2);
    axi_read(32'h0, d, r); chk("bad_wr_nochange", d, 32'h52);
    axi_read(32'hC, d, r); chk("bad_rd_resp", {30'd0, r}, 2); chk("bad_rd_data", d, 0);
    axi_write(32'h4, 32'hFF, r); chk("stat_wr_resp", {30'd0, r}, 0);
    axi_read(32'h4, d, r); chk("stat_wr_ignored", d, 0);

    // Reset in the middle of a transfer
    axi_write(32'h8, 32'hFF, r);
    repeat (20) @(negedge clk);
    chk("mid_mosi", {31'd0, o_mosi}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_mosi", {31'd0, o_mosi}, 0);
    chk("abort_sclk", {31'd0, o_sclk}, 0);
    chk("abort_awready", {31'd0, awready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(32'h0, d, r); chk("abort_ctrl", d, 0);
    axi_read(32'h4, d, r); chk("abort_stat", d, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
